mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand and HI/LO width; all verification values use 32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request a mul/div operation; sampled only in IDLE.
REQ-005 Port: op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 Port: SrcA  input  WIDTH  multiplicand/dividend; also the MTHI/MTLO write data.
REQ-007 Port: SrcB  input  WIDTH  multiplier/divisor.
REQ-008 Port: mthi  input  1  load HI from SrcA.
REQ-009 Port: mtlo  input  1  load LO from SrcA.
REQ-010 Port: busy  output  1  high while an operation is in progress (state != IDLE).
REQ-011 Port: done  output  1  one-cycle pulse when HI/LO receive a new result.
REQ-012 Port: div_zero  output  1  sticky flag: the last completed division had SrcB == 0.
REQ-013 Port: hi, lo  output  WIDTH each  architectural HI/LO registers, consumed by the ALU MFHI/MFLO path.

Function
REQ-014 States SHALL be IDLE, RUN and FIX; a 5-bit iteration counter SHALL run 0..31 in RUN.
REQ-015 IDLE with start=1 at edge E0: SHALL latch op, |SrcA| and |SrcB| (signed ops only), and result signs; SHALL go to RUN with counter=0.
REQ-016 RUN SHALL perform one radix-2 step per edge: shift-add for multiply, restoring shift-subtract for divide; after 32 steps (edges E1..E32) it SHALL go to FIX.
REQ-017 FIX at edge E33 SHALL apply sign correction, write HI/LO, assert done for the following cycle, and return to IDLE.
REQ-018 Result latency: hi/lo new and done=1 in the cycle after edge E0+33; busy=1 from after E0 through that edge.
REQ-019 Multiply SHALL give {hi,lo} = the full 64-bit product; MULT SHALL negate the product when the operand signs differ.
REQ-020 Division SHALL give lo=quotient truncated toward zero and hi=remainder; the remainder sign SHALL follow the dividend.
REQ-021 Divide by zero SHALL keep the same latency and give lo=0xFFFFFFFF, hi=SrcA and div_zero=1. Any completed non-zero division SHALL clear div_zero, and multiplies SHALL leave it unchanged.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0, with no exception.
REQ-023 start, mthi and mtlo SHALL be ignored while busy; operand inputs SHALL be don't-care after E0.
REQ-024 In IDLE, mthi/mtlo SHALL write SrcA at the next edge, and both may be asserted together. If start is also asserted, start wins and the moves are dropped.
REQ-025 hi/lo SHALL hold their value across a mul/div until the FIX write.

Reset
REQ-026 rst=1 at any edge SHALL force state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0 and div_zero=0.
REQ-027 Reset mid-operation SHALL abort it with no HI/LO write and no done pulse; rst SHALL take priority over start.

Structure
REQ-028 Package mdu_pkg SHALL hold the op encodings, the state enum and the constant ITER=32.
REQ-029 One sub-module, mdu_negate, SHALL provide conditional two's-complement negation (WIDTH and 2*WIDTH instances) for operand absolute values and result fix-up.
REQ-030 Datapath: one 2*WIDTH accumulator/remainder register, one WIDTH operand register and one WIDTH-bit-plus-carry adder/subtractor, shared between multiply and divide.

Verification
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after the start cycle.
REQ-032 MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064, div_zero=1; then DIVU 100 / 7 -> lo=14, hi=2, div_zero=0.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; start and mthi pulsed during busy -> no effect, single done.
REQ-035 rst asserted 10 cycles into a MULT -> next cycle busy=0, hi=lo=0, and no done pulse; mthi 0x1234 in IDLE -> hi=0x00001234 next cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM states and iteration count for the multiply/divide unit
package mdu_pkg;
    localparam int ITER = 32;
    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_t;
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;
endpackage

// File: rtl/mdu_negate.sv
// mdu_negate: conditional two's-complement negation
module mdu_negate #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);
    assign y = neg ? ~a + W'(1) : a;
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 MULT/MULTU/DIV/DIVU with architectural HI/LO registers
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [4:0] LAST = 5'(ITER - 1);
    state_t             state, state_n;
    logic [4:0]         cnt;
    op_t                op_r;
    logic [2*WIDTH-1:0] acc, acc_step, prod;
    logic [WIDTH-1:0]   b_r, abs_a, abs_b, quo, rem;
    logic               neg_q, neg_r, dz, is_div, sgn_a, sgn_b;
    logic [WIDTH:0]     add_a, add_b;
    logic [WIDTH+1:0]   sum;

    assign busy   = state != IDLE;
    assign is_div = op_r == OP_DIVU || op_r == OP_DIV;
    assign sgn_a  = (op_t'(op) == OP_MULT || op_t'(op) == OP_DIV) && SrcA[WIDTH-1];
    assign sgn_b  = (op_t'(op) == OP_MULT || op_t'(op) == OP_DIV) && SrcB[WIDTH-1];

    mdu_negate #(.W(WIDTH))   u_abs_a (.neg(sgn_a),       .a(SrcA),                 .y(abs_a));
    mdu_negate #(.W(WIDTH))   u_abs_b (.neg(sgn_b),       .a(SrcB),                 .y(abs_b));
    mdu_negate #(.W(2*WIDTH)) u_fix_p (.neg(neg_q),       .a(acc),                  .y(prod));
    mdu_negate #(.W(WIDTH))   u_fix_q (.neg(neg_q && !dz), .a(acc[WIDTH-1:0]),       .y(quo));
    mdu_negate #(.W(WIDTH))   u_fix_r (.neg(neg_r),       .a(acc[2*WIDTH-1:WIDTH]), .y(rem));

    // Shared adder: multiply adds B to the upper half, divide subtracts B from the shifted remainder.
    // With B == 0 the divide degenerates to a plain shift, leaving {|A|, all-ones} in acc.
    always_comb begin
        add_a    = is_div ? acc[2*WIDTH-1:WIDTH-1] : {1'b0, acc[2*WIDTH-1:WIDTH]};
        add_b    = is_div ? ~{1'b0, b_r} : {1'b0, b_r};
        sum      = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+2)'(is_div);
        acc_step = is_div ? (sum[WIDTH+1] ? {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0})
                          : (acc[0] ? {sum[WIDTH:0], acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]});
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = start ? RUN : IDLE;
            RUN:     state_n = (cnt == LAST) ? FIX : RUN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= (state == RUN) ? cnt + 5'd1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_r     <= OP_MULTU;
            acc      <= '0;
            b_r      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= state == FIX;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r  <= op_t'(op);
                        acc   <= {{WIDTH{1'b0}}, abs_a};
                        b_r   <= abs_b;
                        neg_q <= sgn_a ^ sgn_b;
                        neg_r <= sgn_a;
                        dz    <= SrcB == '0;
                    end else begin
                        if (mthi) hi <= SrcA;
                        if (mtlo) lo <= SrcA;
                    end
                end
                RUN: acc <= acc_step;
                FIX: begin
                    {hi, lo} <= is_div ? {rem, quo} : prod;
                    if (is_div) div_zero <= dz;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        rst, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] SrcA, SrcB;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;
    int total = 0;
    int bad = 0;
    logic dz_m;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } res_t;
    res_t sb[$];

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .SrcA(SrcA), .SrcB(SrcB),
        .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic res_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic dz_in);
        res_t r;
        logic [63:0] p;
        logic signed [63:0] sa, sbv, q, m;
        r.dz = dz_in;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        if (o == 2'b00) begin
            p = {32'b0, a} * {32'b0, b};
            {r.hi, r.lo} = p;
        end else if (o == 2'b01) begin
            p = sa * sbv;
            {r.hi, r.lo} = p;
        end else if (b == 32'd0) begin
            r.lo = 32'hFFFFFFFF;
            r.hi = a;
            r.dz = 1'b1;
        end else if (o == 2'b10) begin
            r.lo = a / b;
            r.hi = a % b;
            r.dz = 1'b0;
        end else begin
            q = sa / sbv;
            m = sa % sbv;
            r.lo = q[31:0];
            r.hi = m[31:0];
            r.dz = 1'b0;
        end
        return r;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit inj, input bit mv);
        res_t e;
        logic [31:0] hi0;
        int n;
        e = model(o, a, b, dz_m);
        dz_m = e.dz;
        sb.push_back(e);
        hi0 = hi;
        op = o; SrcA = a; SrcB = b; start = 1'b1; mthi = mv; mtlo = mv;
        tick;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        SrcA = 32'hDEADBEEF; SrcB = 32'h0BAD0BAD; op = ~o;
        n = 1;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start: got %b want 1", busy); end
        while (done !== 1'b1 && n < 100) begin
            if (n == 5 && inj) begin start = 1'b1; mthi = 1'b1; mtlo = 1'b1; end
            if (n == 6) begin start = 1'b0; mthi = 1'b0; mtlo = 1'b0; end
            tick;
            n++;
            if (n == 10) begin
                total++;
                if (hi !== hi0) begin bad++; $display("FAIL hi_hold: got %h want %h", hi, hi0); end
            end
        end
        total++;
        if (n !== 34) begin bad++; $display("FAIL latency op=%0d: got %0d want 34", o, n); end
        e = sb.pop_front();
        total++;
        if (hi !== e.hi) begin bad++; $display("FAIL hi op=%0d a=%h b=%h: got %h want %h", o, a, b, hi, e.hi); end
        total++;
        if (lo !== e.lo) begin bad++; $display("FAIL lo op=%0d a=%h b=%h: got %h want %h", o, a, b, lo, e.lo); end
        total++;
        if (div_zero !== e.dz) begin bad++; $display("FAIL div_zero op=%0d: got %b want %b", o, div_zero, e.dz); end
        tick;
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL done_pulse_width: got %b want 0", done); end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; op = 2'b00; SrcA = 32'd3; SrcB = 32'd4; mthi = 1'b1; mtlo = 1'b1;
        tick; tick; tick;
        dz_m = 1'b0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++;
        if ({done, div_zero} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {done, div_zero}); end
        total++;
        if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL reset_hilo: got %h want 0", {hi, lo}); end
        rst = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        tick;
    endtask

    task automatic test_multu;
        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    endtask

    task automatic test_signed;
        run_op(2'b01, -32'sd3, 32'd5, 0, 0);
        run_op(2'b11, -32'sd7, 32'd2, 0, 0);
        run_op(2'b11, 32'd7, -32'sd2, 0, 0);
        run_op(2'b01, -32'sd40000, -32'sd70000, 0, 0);
    endtask

    task automatic test_div_zero;
        run_op(2'b10, 32'd100, 32'd0, 0, 0);
        run_op(2'b00, 32'd3, 32'd4, 0, 0);
        run_op(2'b11, -32'sd5, 32'd0, 0, 0);
        run_op(2'b10, 32'd100, 32'd7, 0, 0);
    endtask

    task automatic test_overflow_busy;
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 1, 0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++)
            run_op(2'($urandom_range(0, 3)), $urandom,
                   ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom, 0, 0);
    endtask

    task automatic test_start_with_moves;
        run_op(2'b10, 32'hFFFFFFF0, 32'h00010001, 0, 1);
    endtask

    task automatic test_reset_mid;
        int dn;
        op = 2'b01; SrcA = 32'h12345; SrcB = -32'sd9; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (9) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        dz_m = 1'b0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b want 0", busy); end
        total++;
        if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL midreset_hilo: got %h want 0", {hi, lo}); end
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) dn++;
            tick;
        end
        total++;
        if (dn !== 0) begin bad++; $display("FAIL midreset_done: got %0d pulses want 0", dn); end
    endtask

    task automatic test_moves;
        SrcA = 32'h1234; mthi = 1'b1;
        tick;
        mthi = 1'b0;
        total++;
        if (hi !== 32'h00001234) begin bad++; $display("FAIL mthi: got %h want 00001234", hi); end
        total++;
        if (lo !== 32'h0) begin bad++; $display("FAIL mthi_lo_untouched: got %h want 0", lo); end
        SrcA = 32'hA5A5C3C3; mthi = 1'b1; mtlo = 1'b1;
        tick;
        mthi = 1'b0; mtlo = 1'b0;
        total++;
        if ({hi, lo} !== {2{32'hA5A5C3C3}}) begin bad++; $display("FAIL mthi_mtlo: got %h want %h", {hi, lo}, {2{32'hA5A5C3C3}}); end
        SrcA = 32'h77; mtlo = 1'b1;
        tick;
        mtlo = 1'b0;
        total++;
        if ({hi, lo} !== {32'hA5A5C3C3, 32'h77}) begin bad++; $display("FAIL mtlo: got %h want %h", {hi, lo}, {32'hA5A5C3C3, 32'h77}); end
    endtask

    initial begin
        test_reset;
        test_multu;
        test_signed;
        test_div_zero;
        test_overflow_busy;
        test_random;
        test_start_with_moves;
        test_reset_mid;
        test_moves;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
